// File: rtl/ibex_pkg.sv
// Shared types and constants for the IF dummy-instruction insertion stage.
package ibex_pkg;

    // Width of the inserted-dummy performance counter.
    localparam int unsigned DummyCntW = 16;

    // Contents of the IF/ID pipeline register, excluding the valid bit.
    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] pc;
        logic        err;
        logic        is_dummy;
    } if_id_entry_t;

endpackage

// File: rtl/ibex_dummy_perf_cnt.sv
// Saturating event counter. It counts inc_i pulses, holds at all-ones and
// clears only on reset.
module ibex_dummy_perf_cnt #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q;

    // Count up on each event and stop at the maximum value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
            cnt_q <= cnt_q + Width'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ibex_if_dummy_insert.sv
// IF/ID register with dummy-instruction insertion. It multiplexes generator
// dummies into the fetch stream, tags each ID-bound instruction as real or
// dummy, and produces the generator's accept handshake.
// Optional: define IBEX_DUMMY_INSERT_PERF_EN for a saturating inserted-dummy
// counter on dummy_cnt_o. Without it the output is tied to zero.
module ibex_if_dummy_insert
    import ibex_pkg::*;
#(
    parameter bit DummyInstrEn = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 fetch_valid_i,
    input  logic [31:0]          fetch_rdata_i,
    input  logic [31:0]          fetch_addr_i,
    input  logic                 fetch_err_i,
    output logic                 fetch_ready_o,

    input  logic                 insert_dummy_instr_i,
    input  logic [31:0]          dummy_instr_data_i,
    output logic                 dummy_fetch_valid_o,
    output logic                 dummy_id_in_ready_o,

    input  logic                 id_in_ready_i,
    input  logic                 flush_i,

    output logic                 instr_valid_id_o,
    output logic [31:0]          instr_rdata_id_o,
    output logic [31:0]          instr_pc_id_o,
    output logic                 instr_fetch_err_o,
    output logic                 instr_is_dummy_o,
    output logic [DummyCntW-1:0] dummy_cnt_o
);

    logic         instr_valid_q;
    logic         last_dummy_q;
    if_id_entry_t entry_q;

    logic load_en;
    logic ins_ok;

    // The register may load when empty or drained by ID; a flush blocks loading.
    // A dummy never follows a dummy while a real instruction is waiting, so
    // the fetch stream cannot be starved.
    assign load_en = (~instr_valid_q | id_in_ready_i) & ~flush_i;
    assign ins_ok  = DummyInstrEn & insert_dummy_instr_i & ~(last_dummy_q & fetch_valid_i);

    assign fetch_ready_o       = load_en & ~ins_ok & fetch_valid_i;
    assign dummy_id_in_ready_o = load_en & (ins_ok | fetch_valid_i);
    assign dummy_fetch_valid_o = fetch_valid_i;

    // IF/ID register: flush kills, otherwise load dummy, real or empty slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_valid_q <= 1'b0;
            last_dummy_q  <= 1'b0;
            entry_q       <= '0;
        end else if (flush_i) begin
            instr_valid_q <= 1'b0;
            last_dummy_q  <= 1'b0;
        end else if (load_en) begin
            if (ins_ok) begin
                instr_valid_q <= 1'b1;
                last_dummy_q  <= 1'b1;
                entry_q       <= '{rdata: dummy_instr_data_i, pc: fetch_addr_i,
                                   err: 1'b0, is_dummy: 1'b1};
            end else if (fetch_valid_i) begin
                instr_valid_q <= 1'b1;
                last_dummy_q  <= 1'b0;
                entry_q       <= '{rdata: fetch_rdata_i, pc: fetch_addr_i,
                                   err: fetch_err_i, is_dummy: 1'b0};
            end else begin
                instr_valid_q <= 1'b0;
            end
        end
    end

    assign instr_valid_id_o  = instr_valid_q;
    assign instr_rdata_id_o  = entry_q.rdata;
    assign instr_pc_id_o     = entry_q.pc;
    assign instr_fetch_err_o = entry_q.err;
    assign instr_is_dummy_o  = entry_q.is_dummy;

`ifdef IBEX_DUMMY_INSERT_PERF_EN
    logic dummy_load;
    assign dummy_load = load_en & ins_ok;

    ibex_dummy_perf_cnt #(
        .Width (DummyCntW)
    ) u_perf_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (dummy_load),
        .cnt_o  (dummy_cnt_o)
    );
`else
    assign dummy_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ibex_if_dummy_insert.sv
// Directed bench for ibex_if_dummy_insert. A second instance with
// DummyInstrEn = 0 shares all inputs to show that the request is ignored.
module tb_ibex_if_dummy_insert;
    import ibex_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic [31:0] fetch_addr_i;
    logic        fetch_err_i;
    logic        insert_dummy_instr_i;
    logic [31:0] dummy_instr_data_i;
    logic        id_in_ready_i;
    logic        flush_i;

    logic        fetch_ready_o, dummy_fetch_valid_o, dummy_id_in_ready_o;
    logic        instr_valid_id_o, instr_fetch_err_o, instr_is_dummy_o;
    logic [31:0] instr_rdata_id_o, instr_pc_id_o;
    logic [DummyCntW-1:0] dummy_cnt_o;

    logic        nd_fetch_ready, nd_dfv, nd_dir;
    logic        nd_valid, nd_err, nd_is_dummy;
    logic [31:0] nd_rdata, nd_pc;
    logic [DummyCntW-1:0] nd_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    ibex_if_dummy_insert dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .fetch_valid_i        (fetch_valid_i),
        .fetch_rdata_i        (fetch_rdata_i),
        .fetch_addr_i         (fetch_addr_i),
        .fetch_err_i          (fetch_err_i),
        .fetch_ready_o        (fetch_ready_o),
        .insert_dummy_instr_i (insert_dummy_instr_i),
        .dummy_instr_data_i   (dummy_instr_data_i),
        .dummy_fetch_valid_o  (dummy_fetch_valid_o),
        .dummy_id_in_ready_o  (dummy_id_in_ready_o),
        .id_in_ready_i        (id_in_ready_i),
        .flush_i              (flush_i),
        .instr_valid_id_o     (instr_valid_id_o),
        .instr_rdata_id_o     (instr_rdata_id_o),
        .instr_pc_id_o        (instr_pc_id_o),
        .instr_fetch_err_o    (instr_fetch_err_o),
        .instr_is_dummy_o     (instr_is_dummy_o),
        .dummy_cnt_o          (dummy_cnt_o)
    );

    ibex_if_dummy_insert #(.DummyInstrEn(1'b0)) dut_nd (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .fetch_valid_i        (fetch_valid_i),
        .fetch_rdata_i        (fetch_rdata_i),
        .fetch_addr_i         (fetch_addr_i),
        .fetch_err_i          (fetch_err_i),
        .fetch_ready_o        (nd_fetch_ready),
        .insert_dummy_instr_i (insert_dummy_instr_i),
        .dummy_instr_data_i   (dummy_instr_data_i),
        .dummy_fetch_valid_o  (nd_dfv),
        .dummy_id_in_ready_o  (nd_dir),
        .id_in_ready_i        (id_in_ready_i),
        .flush_i              (flush_i),
        .instr_valid_id_o     (nd_valid),
        .instr_rdata_id_o     (nd_rdata),
        .instr_pc_id_o        (nd_pc),
        .instr_fetch_err_o    (nd_err),
        .instr_is_dummy_o     (nd_is_dummy),
        .dummy_cnt_o          (nd_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] rd, input logic [31:0] ad,
                         input logic er, input logic ins, input logic idr, input logic fl);
        fetch_valid_i        = fv;
        fetch_rdata_i        = rd;
        fetch_addr_i         = ad;
        fetch_err_i          = er;
        insert_dummy_instr_i = ins;
        id_in_ready_i        = idr;
        flush_i              = fl;
        #1;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni             = 1'b0;
        dummy_instr_data_i = 32'h02B50033;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check_eq("rst_valid", 32'(instr_valid_id_o), 32'd0);
        check_eq("rst_rdata", instr_rdata_id_o, 32'h0);
        check_eq("rst_pc", instr_pc_id_o, 32'h0);
        check_eq("rst_err", 32'(instr_fetch_err_o), 32'd0);
        check_eq("rst_dummy", 32'(instr_is_dummy_o), 32'd0);
        check_eq("rst_cnt", 32'(dummy_cnt_o), 32'd0);
        rst_ni = 1'b1;

        // Plain real instruction.
        drive(1'b1, 32'h00A00093, 32'h100, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("t1_fetch_ready", 32'(fetch_ready_o), 32'd1);
        check_eq("t1_dummy_id_rdy", 32'(dummy_id_in_ready_o), 32'd1);
        check_eq("t1_dummy_fv", 32'(dummy_fetch_valid_o), 32'd1);
        step();
        check_eq("t1_valid", 32'(instr_valid_id_o), 32'd1);
        check_eq("t1_rdata", instr_rdata_id_o, 32'h00A00093);
        check_eq("t1_pc", instr_pc_id_o, 32'h100);
        check_eq("t1_dummy", 32'(instr_is_dummy_o), 32'd0);

        // Dummy inserted ahead of the waiting 0x104 fetch.
        drive(1'b1, 32'h00B00113, 32'h104, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("t2_fetch_ready", 32'(fetch_ready_o), 32'd0);
        check_eq("t2_dummy_id_rdy", 32'(dummy_id_in_ready_o), 32'd1);
        check_eq("nd_t2_fetch_ready", 32'(nd_fetch_ready), 32'd1);
        step();
        check_eq("t2_rdata", instr_rdata_id_o, 32'h02B50033);
        check_eq("t2_pc", instr_pc_id_o, 32'h104);
        check_eq("t2_dummy", 32'(instr_is_dummy_o), 32'd1);
        check_eq("nd_t2_rdata", nd_rdata, 32'h00B00113);
        check_eq("nd_t2_dummy", 32'(nd_is_dummy), 32'd0);

        // Request still high: the real instruction must go next.
        drive(1'b1, 32'h00B00113, 32'h104, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("t3_fetch_ready", 32'(fetch_ready_o), 32'd1);
        step();
        check_eq("t3_rdata", instr_rdata_id_o, 32'h00B00113);
        check_eq("t3_pc", instr_pc_id_o, 32'h104);
        check_eq("t3_dummy", 32'(instr_is_dummy_o), 32'd0);

        // ID stall: register holds for three cycles.
        drive(1'b1, 32'h00C00193, 32'h108, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("stall%0d_fetch_ready", i), 32'(fetch_ready_o), 32'd0);
            check_eq($sformatf("stall%0d_dummy_id_rdy", i), 32'(dummy_id_in_ready_o), 32'd0);
            step();
            check_eq($sformatf("stall%0d_valid", i), 32'(instr_valid_id_o), 32'd1);
            check_eq($sformatf("stall%0d_rdata", i), instr_rdata_id_o, 32'h00B00113);
            check_eq($sformatf("stall%0d_pc", i), instr_pc_id_o, 32'h104);
        end

        // Flush together with a dummy request and a fetch.
        drive(1'b1, 32'h00C00193, 32'h108, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("flush_fetch_ready", 32'(fetch_ready_o), 32'd0);
        check_eq("flush_dummy_id_rdy", 32'(dummy_id_in_ready_o), 32'd0);
        step();
        check_eq("flush_valid", 32'(instr_valid_id_o), 32'd0);

        // Pending dummy loads once the flush drops.
        drive(1'b1, 32'h00C00193, 32'h108, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("pf_fetch_ready", 32'(fetch_ready_o), 32'd0);
        check_eq("pf_dummy_id_rdy", 32'(dummy_id_in_ready_o), 32'd1);
        step();
        check_eq("pf_valid", 32'(instr_valid_id_o), 32'd1);
        check_eq("pf_rdata", instr_rdata_id_o, 32'h02B50033);
        check_eq("pf_pc", instr_pc_id_o, 32'h108);
        check_eq("pf_dummy", 32'(instr_is_dummy_o), 32'd1);
        check_eq("nd_pf_rdata", nd_rdata, 32'h00C00193);
        check_eq("nd_pf_dummy", 32'(nd_is_dummy), 32'd0);

        // Real instruction with a fetch error.
        drive(1'b1, 32'h00000000, 32'h10C, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        check_eq("err_real_err", 32'(instr_fetch_err_o), 32'd1);
        check_eq("err_real_pc", instr_pc_id_o, 32'h10C);
        check_eq("err_real_dummy", 32'(instr_is_dummy_o), 32'd0);

        // Dummy while the fetch carries an error: dummy error stays clear.
        drive(1'b1, 32'h00000000, 32'h110, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        check_eq("err_dummy_err", 32'(instr_fetch_err_o), 32'd0);
        check_eq("err_dummy_dummy", 32'(instr_is_dummy_o), 32'd1);
        check_eq("err_dummy_pc", instr_pc_id_o, 32'h110);
        check_eq("nd_err_dummy", 32'(nd_is_dummy), 32'd0);

        // Nothing to load: slot empties.
        drive(1'b0, 32'h0, 32'h114, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("empty_dummy_id_rdy", 32'(dummy_id_in_ready_o), 32'd0);
        check_eq("empty_fetch_ready", 32'(fetch_ready_o), 32'd0);
        step();
        check_eq("empty_valid", 32'(instr_valid_id_o), 32'd0);

`ifdef IBEX_DUMMY_INSERT_PERF_EN
        check_eq("cnt_after_3", 32'(dummy_cnt_o), 32'd3);
        // Back-to-back dummies with no fetch waiting, well past saturation.
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 70000; i++) begin
            step();
        end
        check_eq("cnt_saturated", 32'(dummy_cnt_o), 32'h0000FFFF);
`else
        check_eq("cnt_disabled", 32'(dummy_cnt_o), 32'd0);
`endif
        check_eq("nd_cnt", 32'(nd_cnt), 32'd0);

        // Asynchronous reset mid-stream clears the register at once.
        drive(1'b1, 32'h00D00213, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        check_eq("pre_arst_valid", 32'(instr_valid_id_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check_eq("arst_valid", 32'(instr_valid_id_o), 32'd0);
        check_eq("arst_rdata", instr_rdata_id_o, 32'h0);
        check_eq("arst_cnt", 32'(dummy_cnt_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
